// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access unit: FSM states, memory op kinds,
// and the byte width of the external bus.
package mem_access_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    BYTE0,
    BYTE1,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    LB,
    LW,
    SB,
    SW
  } op_e;

  function automatic logic op_is_write(input op_e op);
    return (op == SB) || (op == SW);
  endfunction

  function automatic logic op_is_word(input op_e op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/mau_watchdog.sv
// Loadable down-counter that flags a stalled byte transfer. The count is
// reloaded on every transfer-state entry and expires when it reaches zero.
module mau_watchdog #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its default first, so no branch of the if-chain can leave
  // it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Executes LW/LB/SW/SB against an 8-bit req/ack data memory, splitting word
// accesses into two little-endian byte transfers and stalling until retired.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              word_en,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [BYTE_W-1:0] bus_wdata,
  input  logic [BYTE_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam int WD_W = 8;
  localparam logic [WD_W-1:0] TMO_VAL = WD_W'(TIMEOUT);

  state_e            state_q, state_d;
  op_e               op_q, op_d, op_in;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_in;
  logic [BYTE_W-1:0] wdata_hi_q, wdata_hi_d;
  logic [BYTE_W-1:0] byte0_q, byte0_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_we_q, bus_we_d;
  logic [BYTE_W-1:0] bus_wdata_q, bus_wdata_d;

  logic req_present, in_xfer, xfer_ok;
  logic wd_clear, wd_load, wd_en, wd_expire;

  assign req_present = mem_read | mem_write;
  assign in_xfer     = (state_q == BYTE0) || (state_q == BYTE1);
  // The watchdog expiring withdraws the request so a late ack cannot complete it.
  assign bus_req     = in_xfer & ~wd_expire;
  assign xfer_ok     = bus_req & bus_ack;
  assign stall       = ((state_q == IDLE) & req_present) | in_xfer;

  always_comb begin
    if (mem_write) op_in = word_en ? SW : SB;
    else           op_in = ld_en   ? LW : LB;
    addr_in = op_is_word(op_in) ? {addr[ADDR_W-1:1], 1'b0} : addr;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_hi_d  = wdata_hi_q;
    byte0_d     = byte0_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    wd_clear    = 1'b0;
    wd_load     = 1'b0;
    wd_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_present) begin
          op_d        = op_in;
          addr_d      = addr_in;
          wdata_hi_d  = wdata[2*BYTE_W-1:BYTE_W];
          bus_addr_d  = addr_in;
          bus_we_d    = mem_write;
          bus_wdata_d = mem_write ? wdata[BYTE_W-1:0] : '0;
          wd_load     = 1'b1;
          state_d     = BYTE0;
        end
      end
      BYTE0: begin
        if (xfer_ok) begin
          byte0_d = bus_rdata;
          if (op_is_word(op_q)) begin
            bus_addr_d  = addr_q | ADDR_W'(1);
            bus_wdata_d = op_is_write(op_q) ? wdata_hi_q : '0;
            wd_load     = 1'b1;
            state_d     = BYTE1;
          end else begin
            if (!op_is_write(op_q)) begin
              rdata_d = {{(DATA_W-BYTE_W){bus_rdata[BYTE_W-1]}}, bus_rdata};
            end
            done_d  = 1'b1;
            state_d = DONE;
          end
        end else if (wd_expire) begin
          if (!op_is_write(op_q)) rdata_d = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_en = 1'b1;
        end
      end
      BYTE1: begin
        if (xfer_ok) begin
          if (!op_is_write(op_q)) rdata_d = {bus_rdata, byte0_q};
          done_d  = 1'b1;
          state_d = DONE;
        end else if (wd_expire) begin
          if (!op_is_write(op_q)) rdata_d = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wd_en = 1'b1;
        end
      end
      DONE: begin
        wd_clear = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= LB;
      addr_q      <= '0;
      wdata_hi_q  <= '0;
      byte0_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_hi_q  <= wdata_hi_d;
      byte0_q     <= byte0_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  mau_watchdog #(
    .CNT_W(WD_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .load    (wd_load),
    .en      (wd_en),
    .load_val(TMO_VAL),
    .expire  (wd_expire)
  );

  assign rdata     = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_we    = bus_we_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: a per-transaction timeline model predicts every cycle's
// outputs, a bus monitor logs completed transfers, and directed cases pin the model.
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, word_en, ld_en;
  logic [15:0] addr, wdata, rdata;
  logic        stall, done, err;
  logic        bus_req, bus_we, bus_ack;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .word_en  (word_en),
    .ld_en    (ld_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .err      (err),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  typedef struct {
    bit          chk;
    bit          stall;
    bit          done;
    bit          err;
    bit          req;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdat;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  exp_t        expq[$];
  xfer_t       xlog[$];
  logic [7:0]  mem [0:65535];
  logic [15:0] m_rdata = 16'h0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        p_rd, p_wr, p_word, p_ld;
  logic [15:0] p_addr, p_wdata;
  int          tcyc, done_cyc, abort_at;
  bit          done_seen, err_seen, aborted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_xfer(input string name, input int i, input bit we,
                            input logic [15:0] a, input logic [7:0] d);
    if (i >= xlog.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: transfer %0d missing, only %0d logged", name, i, xlog.size());
      return;
    end
    check({name, "_we"}, xlog[i].we, we);
    check({name, "_addr"}, xlog[i].addr, a);
    if (we) check({name, "_data"}, xlog[i].data, d);
  endtask

  // One clock cycle: apply pending inputs and bus response, queue expectation.
  task automatic step(input exp_t e, input bit ack, input logic [7:0] rd);
    if (aborted) return;
    tcyc++;
    @(posedge clk);
    #1;
    mem_read  = p_rd;
    mem_write = p_wr;
    word_en   = p_word;
    ld_en     = p_ld;
    addr      = p_addr;
    wdata     = p_wdata;
    bus_ack   = ack;
    bus_rdata = rd;
    if (tcyc == abort_at) begin
      e.chk = 1'b0;
      expq.push_back(e);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      p_rd      = 1'b0;
      p_wr      = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_bus_req", bus_req, 0);
      check("rst_stall", stall, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rdata", rdata, 0);
      check("rst_bus_we", bus_we, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      #1 rst_n = 1'b1;
      m_rdata = 16'h0;
      aborted = 1'b1;
      @(negedge clk);
      return;
    end
    expq.push_back(e);
    @(negedge clk);
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = tcyc;
      err_seen  = err;
    end
  endtask

  task automatic idle(input int n);
    exp_t e;
    aborted = 1'b0;
    p_rd = 1'b0;
    p_wr = 1'b0;
    e = '{chk: 1'b1, stall: 1'b0, done: 1'b0, err: 1'b0, req: 1'b0, we: 1'b0,
          addr: 16'h0, wdat: 8'h0, rdata: m_rdata};
    repeat (n) begin
      p_addr = 16'($urandom);
      step(e, 1'($urandom), 8'($urandom));
    end
  endtask

  // w0/w1: cycles the memory holds ack low per byte; w >= TMO means it never acks.
  task automatic run_txn(input bit wr, input bit both, input bit word, input logic [15:0] a,
                         input logic [15:0] wd, input int w0, input int w1);
    exp_t        e;
    logic [15:0] base;
    logic [7:0]  got0, got1, b_rd;
    bit          terr;
    int          nb;
    tcyc = 0; done_cyc = 0; done_seen = 1'b0; err_seen = 1'b0; aborted = 1'b0;
    base = word ? (a & 16'hFFFE) : a;
    nb   = word ? 2 : 1;
    terr = 1'b0; got0 = 8'h0; got1 = 8'h0;
    p_rd    = !wr || both;
    p_wr    = wr;
    p_word  = wr ? word : 1'($urandom);
    p_ld    = wr ? 1'($urandom) : word;
    p_addr  = a;
    p_wdata = wd;
    e = '{chk: 1'b1, stall: 1'b1, done: 1'b0, err: 1'b0, req: 1'b0, we: 1'b0,
          addr: 16'h0, wdat: 8'h0, rdata: m_rdata};
    step(e, 1'($urandom), 8'($urandom));
    for (int b = 0; b < nb && !terr; b++) begin
      int w;
      w      = (b == 0) ? w0 : w1;
      e.req  = 1'b1;
      e.we   = wr;
      e.addr = base | 16'(b);
      e.wdat = wr ? wd[8*b +: 8] : 8'h0;
      if (w < TMO) begin
        repeat (w) step(e, 1'b0, 8'($urandom));
        b_rd = mem[e.addr];
        step(e, 1'b1, b_rd);
        if (!aborted) begin
          if (wr) mem[e.addr] = e.wdat;
          else if (b == 0) got0 = b_rd;
          else got1 = b_rd;
        end
      end else begin
        repeat (TMO) step(e, 1'b0, 8'($urandom));
        e.req = 1'b0;
        step(e, 1'b1, 8'($urandom));
        terr = 1'b1;
      end
    end
    if (!wr && !aborted) begin
      if (terr)      m_rdata = 16'h0;
      else if (word) m_rdata = {got1, got0};
      else           m_rdata = {{8{got0[7]}}, got0};
    end
    e = '{chk: 1'b1, stall: 1'b0, done: 1'b1, err: terr, req: 1'b0, we: 1'b0,
          addr: 16'h0, wdat: 8'h0, rdata: m_rdata};
    step(e, 1'($urandom), 8'($urandom));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (e.chk) begin
        check("stall", stall, e.stall);
        check("done", done, e.done);
        check("err", err, e.err);
        check("bus_req", bus_req, e.req);
        check("rdata", rdata, e.rdata);
        if (e.req) begin
          check("bus_addr", bus_addr, e.addr);
          check("bus_we", bus_we, e.we);
          if (e.we) check("bus_wdata", bus_wdata, e.wdat);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus_req && bus_ack) xlog.push_back('{bus_we, bus_addr, bus_wdata});
  end

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; word_en = 1'b0; ld_en = 1'b0;
    addr = 16'h0; wdata = 16'h0; bus_ack = 1'b0; bus_rdata = 8'h0;
    p_rd = 1'b0; p_wr = 1'b0; p_word = 1'b0; p_ld = 1'b0; p_addr = 16'h0; p_wdata = 16'h0;
    abort_at = 0; aborted = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    #1;
    check("reset_rdata", rdata, 0);
    check("reset_stall", stall, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_bus_req", bus_req, 0);
    check("reset_bus_we", bus_we, 0);
    check("reset_bus_addr", bus_addr, 0);
    check("reset_bus_wdata", bus_wdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    mem[16'h0010] = 8'h34;
    mem[16'h0011] = 8'h12;
    xlog.delete();
    run_txn(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0, 0, 0);
    check("lw_done_cycle", done_cyc, 4);
    check("lw_rdata", rdata, 16'h1234);
    check("lw_nxfer", xlog.size(), 2);
    check_xfer("lw_x0", 0, 1'b0, 16'h0010, 8'h0);
    check_xfer("lw_x1", 1, 1'b0, 16'h0011, 8'h0);

    mem[16'h0021] = 8'h80;
    xlog.delete();
    run_txn(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0, 0, 0);
    check("lb_done_cycle", done_cyc, 3);
    check("lb_neg_rdata", rdata, 16'hFF80);
    check("lb_nxfer", xlog.size(), 1);
    check_xfer("lb_x0", 0, 1'b0, 16'h0021, 8'h0);
    mem[16'h0021] = 8'h7F;
    run_txn(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0, 0, 0);
    check("lb_pos_rdata", rdata, 16'h007F);

    xlog.delete();
    run_txn(1'b1, 1'b0, 1'b1, 16'h0033, 16'hBEEF, 0, 0);
    check("sw_rdata_kept", rdata, 16'h007F);
    check("sw_nxfer", xlog.size(), 2);
    check_xfer("sw_x0", 0, 1'b1, 16'h0032, 8'hEF);
    check_xfer("sw_x1", 1, 1'b1, 16'h0033, 8'hBE);

    xlog.delete();
    run_txn(1'b1, 1'b1, 1'b0, 16'h0005, 16'hBEEF, 0, 0);
    check("sb_nxfer", xlog.size(), 1);
    check_xfer("sb_x0", 0, 1'b1, 16'h0005, 8'hEF);

    run_txn(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0, 2, 2);
    check("lw_slow_done_cycle", done_cyc, 8);
    check("lw_slow_rdata", rdata, 16'h1234);

    idle(1);
    run_txn(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0, TMO + 3, 0);
    check("tmo_done_cycle", done_cyc, 7);
    check("tmo_err", err_seen, 1);
    check("tmo_rdata", rdata, 16'h0);
    run_txn(1'b1, 1'b0, 1'b0, 16'h0007, 16'h1234, 1, 0);
    check("after_tmo_err", err_seen, 0);
    check("after_tmo_done_cycle", done_cyc, 4);

    abort_at = 4;
    run_txn(1'b1, 1'b0, 1'b1, 16'h0040, 16'hA55A, 0, 3);
    abort_at = 0;
    check("rst_no_done", done_seen, 0);
    idle(3);

    xlog.delete();
    run_txn(1'b0, 1'b0, 1'b1, 16'h0050, 16'h0, 0, 0);
    run_txn(1'b1, 1'b0, 1'b1, 16'h0050, 16'h1357, 0, 0);
    run_txn(1'b0, 1'b0, 1'b1, 16'h0050, 16'h0, 0, 0);
    check("b2b_nxfer", xlog.size(), 6);
    check("b2b_rdata", rdata, 16'h1357);

    for (int n = 0; n < 300; n++) begin
      bit          wr, both, word;
      logic [15:0] a;
      int          w0, w1;
      wr   = 1'($urandom);
      both = ($urandom_range(0, 3) == 0);
      word = 1'($urandom);
      a    = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63));
      w0   = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 2);
      w1   = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 2);
      run_txn(wr, both, word, a, 16'($urandom), w0, w1);
      idle($urandom_range(0, 2));
    end

    idle(3);
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
